// File: rtl/fifo_frame_scheduler.sv
// fifo_frame_scheduler: flushes the sample FIFO to the UART TX as header/length/payload/checksum frames
module fifo_frame_scheduler #(
    parameter int MAX_PAYLOAD = 8,
    parameter int FLUSH_CYCLES = 1000,
    parameter logic [7:0] HEADER = 8'hA5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fifo_empty,
    input  logic        fifo_full,
    input  logic [7:0]  fifo_rd_data,
    output logic        fifo_read,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        busy,
    output logic [15:0] frame_count
);
    localparam int TW = $clog2(FLUSH_CYCLES + 1);
    typedef enum logic [2:0] {IDLE, LOAD, HDR, LEN, PAY, CHK} state_t;
    state_t state, nxt;
    logic [TW-1:0] timer;
    logic [3:0] n, idx, idx_nxt;
    logic [7:0] csum, data_nxt;
    logic [7:0] mem [16];
    logic accept, trigger;
    assign accept = tx_valid && tx_ready;
    assign trigger = !fifo_empty && (fifo_full || timer == TW'(FLUSH_CYCLES - 1));
    assign fifo_read = state == LOAD && !fifo_empty && n < 4'(MAX_PAYLOAD);
    assign busy = state != IDLE;
    always_comb begin
        nxt = state;
        idx_nxt = idx;
        case (state)
            IDLE: nxt = trigger ? LOAD : IDLE;
            LOAD: nxt = (fifo_empty || n == 4'(MAX_PAYLOAD - 1)) ? HDR : LOAD;
            HDR: nxt = accept ? LEN : HDR;
            LEN: nxt = accept ? PAY : LEN;
            PAY: begin
                nxt = (accept && idx == n - 4'd1) ? CHK : PAY;
                idx_nxt = accept ? idx + 4'd1 : idx;
            end
            default: nxt = accept ? IDLE : CHK;
        endcase
        // tx_data is loaded with the byte of the state being entered, so it is stable while stalled
        data_nxt = nxt == HDR ? HEADER :
                   nxt == LEN ? {4'b0, n} :
                   nxt == PAY ? mem[idx_nxt] :
                   nxt == CHK ? csum ^ {4'b0, n} : 8'h00;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            timer <= '0;
            n <= '0;
            idx <= '0;
            csum <= '0;
            tx_valid <= 1'b0;
            tx_data <= 8'h00;
            frame_count <= '0;
        end else begin
            state <= nxt;
            tx_valid <= nxt != IDLE && nxt != LOAD;
            tx_data <= data_nxt;
            idx <= idx_nxt;
            timer <= (state != IDLE || fifo_empty) ? '0 : timer + 1'b1;
            if (state == IDLE && trigger) begin
                n <= '0;
                idx <= '0;
                csum <= '0;
            end
            if (fifo_read) begin
                n <= n + 4'd1;
                csum <= csum ^ fifo_rd_data;
            end
            if (state == CHK && accept)
                frame_count <= frame_count + 16'd1;
        end
    end
    always_ff @(posedge clk)
        if (fifo_read)
            mem[n] <= fifo_rd_data;
endmodule

// File: tb/tb_fifo_frame_scheduler.sv
// tb_fifo_frame_scheduler: randomized frame checks against a queue-based FIFO and frame model
module tb_fifo_frame_scheduler;
    localparam int MP = 8;
    localparam int FC = 20;
    typedef logic [7:0] bq_t[$];
    logic clk = 0;
    logic reset = 1;
    logic tx_ready = 1;
    logic fifo_empty, fifo_full, fifo_read, tx_valid, busy;
    logic [7:0] fifo_rd_data, tx_data;
    logic [15:0] frame_count;
    logic [15:0] efc = 0;
    logic [7:0] fq [16];
    int head = 0;
    int cnt = 0;
    int compared = 0;
    int mismatched = 0;
    int pops, loadc, sendc, bad_pops = 0;
    bit rnd_rdy = 0;
    bq_t got;

    always #5 clk = ~clk;
    assign fifo_empty = cnt == 0;
    assign fifo_full = cnt == 16;
    assign fifo_rd_data = fq[head];

    fifo_frame_scheduler #(.MAX_PAYLOAD(MP), .FLUSH_CYCLES(FC), .HEADER(8'hA5)) dut (
        .clk(clk), .reset(reset), .fifo_empty(fifo_empty), .fifo_full(fifo_full),
        .fifo_rd_data(fifo_rd_data), .fifo_read(fifo_read), .tx_data(tx_data),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy), .frame_count(frame_count)
    );

    task automatic push(input logic [7:0] b);
        if (cnt < 16) begin
            fq[(head + cnt) % 16] = b;
            cnt++;
        end
    endtask

    task automatic step();
        logic rd, acc;
        logic [7:0] d;
        #1;
        rd = fifo_read;
        acc = tx_valid && tx_ready;
        d = tx_data;
        if (rd && cnt == 0) bad_pops++;
        if (busy && !tx_valid) loadc++;
        if (tx_valid) sendc++;
        @(posedge clk);
        #1;
        if (rd && cnt > 0) begin
            head = (head + 1) % 16;
            cnt--;
            pops++;
        end
        if (acc) got.push_back(d);
        if (rnd_rdy) tx_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic wait_busy(output int c);
        c = 0;
        while (!busy && c < 5000) begin
            step();
            c++;
        end
    endtask

    task automatic collect(input int stall_at, input logic [7:0] stall_byte, input int stop_at);
        int b = 0;
        got.delete();
        pops = 0;
        loadc = 0;
        sendc = 0;
        while (busy && b < 2000 && got.size() != stop_at) begin
            if (got.size() == stall_at) begin
                stall_at = -1;
                tx_ready = 0;
                repeat (5) begin
                    compared++;
                    if (tx_valid !== 1'b1 || tx_data !== stall_byte) begin
                        mismatched++;
                        $display("FAIL stall_hold: tx_valid=%b tx_data=%h, required 1/%h", tx_valid, tx_data, stall_byte);
                    end
                    step();
                end
                tx_ready = 1;
            end
            step();
            b++;
        end
        if (b >= 2000) begin
            mismatched++;
            $display("FAIL collect_timeout: busy=%b after %0d cycles, required 0", busy, b);
        end
    endtask

    function automatic bq_t mkframe(input bq_t d);
        bq_t f;
        logic [7:0] x;
        x = 8'(d.size());
        f.push_back(8'hA5);
        f.push_back(x);
        foreach (d[i]) begin
            f.push_back(d[i]);
            x ^= d[i];
        end
        f.push_back(x);
        return f;
    endfunction

    function automatic bit same(input bq_t e);
        if (got.size() != e.size()) return 0;
        foreach (e[i]) if (got[i] !== e[i]) return 0;
        return 1;
    endfunction

    task automatic test_reset();
        repeat (3) step();
        compared += 5;
        if (fifo_read !== 1'b0) begin mismatched++; $display("FAIL rst_fifo_read: got %b required 0", fifo_read); end
        if (tx_valid !== 1'b0) begin mismatched++; $display("FAIL rst_tx_valid: got %b required 0", tx_valid); end
        if (tx_data !== 8'h00) begin mismatched++; $display("FAIL rst_tx_data: got %h required 00", tx_data); end
        if (busy !== 1'b0) begin mismatched++; $display("FAIL rst_busy: got %b required 0", busy); end
        if (frame_count !== 16'h0) begin mismatched++; $display("FAIL rst_frame_count: got %h required 0000", frame_count); end
        reset = 0;
        repeat (3) step();
    endtask

    task automatic test_timeout();
        bq_t d, e;
        int c;
        d.push_back(8'h11); d.push_back(8'h22); d.push_back(8'h33);
        foreach (d[i]) push(d[i]);
        wait_busy(c);
        compared++;
        if (c != FC) begin mismatched++; $display("FAIL timeout_latency: got %0d cycles required %0d", c, FC); end
        collect(-1, 8'h00, -1);
        e = mkframe(d);
        efc++;
        compared += 5;
        if (!same(e)) begin mismatched++; $display("FAIL timeout_frame: got %p required %p", got, e); end
        if (pops != 3) begin mismatched++; $display("FAIL timeout_pops: got %0d required 3", pops); end
        if (loadc != 4) begin mismatched++; $display("FAIL timeout_load_cycles: got %0d required 4", loadc); end
        if (sendc != 6) begin mismatched++; $display("FAIL timeout_send_cycles: got %0d required 6", sendc); end
        if (frame_count !== efc) begin mismatched++; $display("FAIL timeout_count: got %0d required %0d", frame_count, efc); end
    endtask

    task automatic test_full();
        bq_t d0, d1, e;
        int c;
        for (int i = 0; i < 16; i++) begin
            push(8'(i));
            if (i < 8) d0.push_back(8'(i)); else d1.push_back(8'(i));
        end
        wait_busy(c);
        compared++;
        if (c != 1) begin mismatched++; $display("FAIL full_latency: got %0d cycles required 1", c); end
        collect(-1, 8'h00, -1);
        e = mkframe(d0);
        efc++;
        compared += 3;
        if (!same(e)) begin mismatched++; $display("FAIL full_frame1: got %p required %p", got, e); end
        if (e[10] !== 8'h08) begin mismatched++; $display("FAIL full_chk_model: got %h required 08", e[10]); end
        if (loadc != MP) begin mismatched++; $display("FAIL full_load_cycles: got %0d required %0d", loadc, MP); end
        wait_busy(c);
        compared++;
        if (c != FC) begin mismatched++; $display("FAIL full_second_latency: got %0d required %0d", c, FC); end
        collect(-1, 8'h00, -1);
        e = mkframe(d1);
        efc++;
        compared += 2;
        if (!same(e)) begin mismatched++; $display("FAIL full_frame2: got %p required %p", got, e); end
        if (frame_count !== efc) begin mismatched++; $display("FAIL full_count: got %0d required %0d", frame_count, efc); end
    endtask

    task automatic test_backpressure();
        bq_t d, e;
        int c;
        repeat (4) d.push_back(8'($urandom));
        foreach (d[i]) push(d[i]);
        wait_busy(c);
        collect(3, d[1], -1);
        e = mkframe(d);
        efc++;
        compared += 2;
        if (!same(e)) begin mismatched++; $display("FAIL bp_frame: got %p required %p", got, e); end
        if (frame_count !== efc) begin mismatched++; $display("FAIL bp_count: got %0d required %0d", frame_count, efc); end
    endtask

    task automatic test_concurrent();
        bq_t d, e;
        int c;
        d.push_back(8'($urandom)); d.push_back(8'($urandom));
        push(d[0]);
        wait_busy(c);
        push(d[1]);
        collect(-1, 8'h00, -1);
        e = mkframe(d);
        efc++;
        compared += 2;
        if (!same(e)) begin mismatched++; $display("FAIL concurrent_frame: got %p required %p", got, e); end
        if (loadc != 3) begin mismatched++; $display("FAIL concurrent_load_cycles: got %0d required 3", loadc); end
    endtask

    task automatic test_reset_mid();
        bq_t d, e;
        int c;
        repeat (5) d.push_back(8'($urandom));
        foreach (d[i]) push(d[i]);
        wait_busy(c);
        collect(-1, 8'h00, 4);
        reset = 1;
        #1;
        compared += 5;
        if (tx_valid !== 1'b0) begin mismatched++; $display("FAIL midrst_tx_valid: got %b required 0", tx_valid); end
        if (busy !== 1'b0) begin mismatched++; $display("FAIL midrst_busy: got %b required 0", busy); end
        if (frame_count !== 16'h0) begin mismatched++; $display("FAIL midrst_count: got %0d required 0", frame_count); end
        if (fifo_read !== 1'b0) begin mismatched++; $display("FAIL midrst_fifo_read: got %b required 0", fifo_read); end
        if (pops != 5) begin mismatched++; $display("FAIL midrst_pops: got %0d required 5", pops); end
        step();
        reset = 0;
        efc = 0;
        d.delete();
        repeat (2) d.push_back(8'($urandom));
        foreach (d[i]) push(d[i]);
        wait_busy(c);
        collect(-1, 8'h00, -1);
        e = mkframe(d);
        efc++;
        compared += 2;
        if (!same(e)) begin mismatched++; $display("FAIL midrst_frame: got %p required %p", got, e); end
        if (frame_count !== efc) begin mismatched++; $display("FAIL midrst_count2: got %0d required %0d", frame_count, efc); end
    endtask

    task automatic test_timer_restart();
        bq_t d, e;
        int c;
        push(8'h5A);
        repeat (FC - 2) step();
        cnt = 0;
        repeat (3) begin
            compared++;
            if (busy !== 1'b0) begin mismatched++; $display("FAIL restart_early: busy=%b required 0", busy); end
            step();
        end
        force dut.frame_count = 16'hFFFF;
        #1;
        release dut.frame_count;
        efc = 16'hFFFF;
        d.push_back(8'($urandom)); d.push_back(8'($urandom));
        foreach (d[i]) push(d[i]);
        wait_busy(c);
        compared++;
        if (c != FC) begin mismatched++; $display("FAIL restart_latency: got %0d required %0d", c, FC); end
        collect(-1, 8'h00, -1);
        e = mkframe(d);
        efc++;
        compared += 2;
        if (!same(e)) begin mismatched++; $display("FAIL restart_frame: got %p required %p", got, e); end
        if (frame_count !== efc) begin mismatched++; $display("FAIL wrap_count: got %h required %h", frame_count, efc); end
    endtask

    task automatic test_random();
        bq_t all, d, e;
        int c, k, first;
        rnd_rdy = 1;
        for (int it = 0; it < 6; it++) begin
            all.delete();
            k = $urandom_range(1, 16);
            repeat (k) all.push_back(8'($urandom));
            foreach (all[i]) push(all[i]);
            first = 1;
            while (all.size() > 0) begin
                d.delete();
                while (all.size() > 0 && d.size() < MP) d.push_back(all.pop_front());
                wait_busy(c);
                compared++;
                if (c != ((first && k == 16) ? 1 : FC)) begin
                    mismatched++;
                    $display("FAIL rand_latency: iter %0d got %0d cycles required %0d", it, c, (first && k == 16) ? 1 : FC);
                end
                first = 0;
                collect(-1, 8'h00, -1);
                e = mkframe(d);
                efc++;
                compared += 2;
                if (!same(e)) begin mismatched++; $display("FAIL rand_frame: iter %0d got %p required %p", it, got, e); end
                if (frame_count !== efc) begin mismatched++; $display("FAIL rand_count: got %0d required %0d", frame_count, efc); end
            end
        end
        rnd_rdy = 0;
        tx_ready = 1;
        compared++;
        if (bad_pops != 0) begin mismatched++; $display("FAIL pop_when_empty: got %0d pops required 0", bad_pops); end
    endtask

    initial begin
        test_reset();
        test_timeout();
        test_full();
        test_backpressure();
        test_concurrent();
        test_reset_mid();
        test_timer_restart();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/fifo_frame_scheduler.md
# fifo_frame_scheduler

Drains the sample FIFO into the UART transmitter as framed packets. The block sits between the 16-entry sample FIFO and the UART TX. It decides when to flush: on FIFO full, or on a programmable idle timeout. It prefetches up to MAX_PAYLOAD samples into local storage, then emits header, length, payload and an XOR checksum over a valid/ready byte handshake.

## Interface
- MAX_PAYLOAD, 8: maximum payload bytes per frame (1..15).
- FLUSH_CYCLES, 1000: cycles the FIFO must be continuously non-empty in IDLE before a flush (>=1).
- HEADER, 8'hA5: frame start byte.
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high.
- fifo_empty  in  1  FIFO empty flag.
- fifo_full  in  1  FIFO full flag.
- fifo_rd_data  in  8  FIFO head entry (asynchronous read, valid while !fifo_empty).
- fifo_read  out  1  pop strobe; FIFO advances on the clk edge where it is high.
- tx_data  out  8  byte to UART.
- tx_valid  out  1  tx_data valid.
- tx_ready  in  1  UART accepts the byte on an edge where tx_valid and tx_ready are both high.
- busy  out  1  high in any state other than IDLE.
- frame_count  out  16  frames completed; wraps modulo 2^16.

## Operation
- States: IDLE, LOAD, HDR, LEN, PAY, CHK.
- IDLE:
  - Flush timer clears whenever fifo_empty=1 and increments each cycle fifo_empty=0.
  - trigger = !fifo_empty && (fifo_full || timer == FLUSH_CYCLES-1).
  - On trigger: go to LOAD; clear byte count n, payload index and checksum.
- LOAD:
  - fifo_read = (state==LOAD) && !fifo_empty && n<MAX_PAYLOAD. This is combinational and is the only source of fifo_read.
  - On each pop edge, capture fifo_rd_data into buf[n], update chk ^= byte, n++.
  - Exit to HDR on the edge that pops byte number MAX_PAYLOAD, or on the first LOAD cycle with fifo_empty=1 (no pop that cycle).
  - FIFO writes during LOAD are legal. Entries popped before exit belong to this frame.
- HDR: tx_data=HEADER.
- LEN: tx_data={4'b0,n}.
- PAY: tx_data=buf[idx]. idx advances on each accepted byte. Leave PAY after byte n-1 is accepted.
- CHK: tx_data = n ^ buf[0] ^ ... ^ buf[n-1].
  - On acceptance: frame_count++, then go to IDLE with the timer cleared.
- Each send state advances only on a handshake edge (tx_valid && tx_ready).
- n is always >= 1, because a trigger requires a non-empty FIFO.
- The block never pops from an empty FIFO.
- Reset (any time, including mid-frame):
  - Return to IDLE immediately. Partially sent frames are abandoned.
  - Already popped bytes are lost and are not re-inserted.

## Timing
- Reset values: fifo_read=0, tx_valid=0, tx_data=8'h00, busy=0, frame_count=0, timer=0, n=0.
- tx_valid and tx_data are registered:
  - tx_valid is high in HDR/LEN/PAY/CHK and low in IDLE/LOAD.
  - tx_valid never depends combinationally on tx_ready.
  - While tx_valid=1 and tx_ready=0, tx_data must stay stable.
- Timeout trigger: the FIFO going non-empty at cycle 0 triggers at cycle FLUSH_CYCLES-1, and LOAD starts at cycle FLUSH_CYCLES. If fifo_full rises first, trigger is immediate.
- LOAD duration:
  - n cycles when n==MAX_PAYLOAD.
  - n+1 cycles otherwise (the extra cycle sees empty).
- Send phase: with tx_ready tied high, n+3 consecutive cycles, one byte per cycle, with no bubbles between bytes.
- After CHK acceptance, busy drops the next cycle. A new trigger cannot occur earlier than FLUSH_CYCLES cycles after entry to IDLE, unless fifo_full=1.

## Test plan
- Timeout flush: FLUSH_CYCLES=4; push 0x11,0x22,0x33; tx_ready=1.
  - Required: fifo_read pulses exactly 3 times.
  - Required bytes: A5, 03, 11, 22, 33, 03. frame_count=1; busy=0 afterwards.
- Full trigger: fill FIFO with 16 bytes 0x00..0x0F, FLUSH_CYCLES=1000, MAX_PAYLOAD=8.
  - Required: frame A5 08 00..07 chk=0x08^0x00^..^0x07 = 0x08, sent well before timeout.
  - The second frame waits for timeout, then sends A5 08 08..0F 0x08.
- Backpressure: during the 2nd payload byte, hold tx_ready=0 for 5 cycles.
  - Required: tx_valid=1 and tx_data unchanged for all 5 cycles.
  - No byte is skipped or duplicated; total frame is unchanged.
- Concurrent write: one byte present at trigger; push a second byte during the first LOAD cycle.
  - Required: the frame carries n=2 when the FIFO is non-empty at the second LOAD cycle; the checksum covers both bytes.
- Reset mid-frame: assert reset during PAY with 3 bytes left.
  - Required: next cycle tx_valid=0, busy=0, frame_count=0, fifo_read=0.
  - Later data produces a fresh frame starting with A5.
- Timer restart: FIFO non-empty for FLUSH_CYCLES-2 cycles, then drained externally to empty, then refilled.
  - Required: no trigger until FLUSH_CYCLES-1 cycles after the refill; frame_count wraps 0xFFFF->0x0000 when preloaded by a force.
